// File: rtl/serial_operand_feeder.sv
// Captures two N-bit operands on load and streams them LSB-first on x1/x2.
// Optional macro SINGLE_STEP_EN: advance one bit per synchronised press of step.
module serial_operand_feeder #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          CP,
  input  logic          CI,
  input  logic          load,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic          step,
  output logic          x1,
  output logic          x2,
  output logic          valid,
  output logic          first,
  output logic [IW-1:0] bit_idx,
  output logic          busy,
  output logic          done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [1:0]    state;
  logic [N-1:0]  sa, sb;
  logic [IW-1:0] cnt;
  logic          advance;

`ifdef SINGLE_STEP_EN
  // Two sync flops plus one history flop for rising-edge detection.
  logic [2:0] step_sync;
  always_ff @(posedge CP or posedge CI) begin
    if (CI) step_sync <= '0;
    else    step_sync <= {step_sync[1:0], step};
  end
  assign advance = step_sync[1] & ~step_sync[2];
`else
  logic unused_step;
  assign unused_step = step;
  assign advance     = 1'b1;
`endif

  always_ff @(posedge CP or posedge CI) begin
    if (CI) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sa    <= A;
          sb    <= B;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: if (advance) begin
          if (cnt == LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign valid   = (state == SHIFT);
  assign busy    = valid;
  assign done    = (state == DONE);
  assign x1      = sa[0] & valid;
  assign x2      = sb[0] & valid;
  assign bit_idx = cnt;
  assign first   = valid && (cnt == '0);
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: table-driven transfers with a scoreboard
// queue, plus sequences for load-while-busy, back-to-back, abort and stepping.
module tb_serial_operand_feeder;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          CP = 1'b0, CI = 1'b1, load = 1'b0, step = 1'b0;
  logic [N-1:0]  A = '0, B = '0;
  logic          x1, x2, valid, first, busy, done;
  logic [IW-1:0] bit_idx;

  serial_operand_feeder #(.N(N), .IW(IW)) dut (
    .CP(CP), .CI(CI), .load(load), .A(A), .B(B), .step(step),
    .x1(x1), .x2(x2), .valid(valid), .first(first), .bit_idx(bit_idx),
    .busy(busy), .done(done)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic          x1, x2, first;
    logic [IW-1:0] idx;
  } exp_t;

  typedef struct {
    logic [N-1:0] a, b;
    int           nvalid;
  } vec_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0, vcnt = 0, dcnt = 0;
  bit sb_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_xfer(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = 0; i < N; i++) q.push_back('{a[i], b[i], (i == 0), IW'(i)});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 40) begin @(negedge CP); k++; end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  // Scoreboard: every valid cycle must match the oldest expected bit.
  always @(negedge CP) begin
    if (valid) vcnt++;
    if (done)  dcnt++;
    if (sb_en && valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("stream", {x1, x2, first, bit_idx}, e);
      end
    end
  end

  vec_t vecs[4];
  int   firsts[$];

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8};
    vecs[1] = '{8'hFF, 8'h00, 8};
    vecs[2] = '{8'h01, 8'h80, 8};
    vecs[3] = '{8'h5A, 8'hC3, 8};

    #12;
    chk("reset_outputs", {x1, x2, valid, first, busy, done, bit_idx}, 0);
    @(negedge CP); CI = 1'b0;
    @(negedge CP);
    chk("idle_outputs", {x1, x2, valid, first, busy, done, bit_idx}, 0);

`ifdef SINGLE_STEP_EN
    A = 8'hA5; B = 8'h3C; load = 1'b1;
    @(negedge CP); load = 1'b0;
    repeat (10) @(negedge CP);
    chk("step_wait_idx", {valid, first, bit_idx}, {1'b1, 1'b1, 3'd0});
    for (int p = 1; p <= 3; p++) begin
      step = 1'b1; repeat (20) @(negedge CP);
      step = 1'b0; repeat (20) @(negedge CP);
      chk("step_idx", {valid, bit_idx}, {1'b1, IW'(p)});
      chk("step_x1", x1, vecs[0].a[p]);
    end
`else
    // Table-driven transfers through the scoreboard.
    sb_en = 1'b1;
    foreach (vecs[v]) begin
      vcnt = 0; dcnt = 0;
      A = vecs[v].a; B = vecs[v].b; load = 1'b1;
      push_xfer(vecs[v].a, vecs[v].b);
      @(negedge CP); load = 1'b0;
      wait_done("xfer");
      chk("xfer_drained", q.size(), 0);
      chk("xfer_nvalid", vcnt, vecs[v].nvalid);
      @(negedge CP);
      chk("xfer_after_done", {done, busy, valid}, 0);
      chk("xfer_done_width", dcnt, 1);
    end

    // Load asserted while busy, with different operands, must be ignored.
    vcnt = 0;
    A = 8'hA5; B = 8'h3C; load = 1'b1;
    push_xfer(8'hA5, 8'h3C);
    @(negedge CP); load = 1'b0;
    begin
      int k = 0;
      while (bit_idx != 3 && k < 20) begin @(negedge CP); k++; end
    end
    A = 8'hFF; B = 8'hFF; load = 1'b1;
    @(negedge CP); load = 1'b0;
    wait_done("busy_load");
    chk("busy_load_drained", q.size(), 0);
    chk("busy_load_nvalid", vcnt, 8);
    @(negedge CP);
    chk("busy_load_idle", busy, 0);
    sb_en = 1'b0;

    // Held load: transfers repeat every N+2 cycles.
    repeat (2) @(negedge CP);
    A = 8'hA5; B = 8'h3C; load = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge CP);
      if (first) firsts.push_back(c);
    end
    load = 1'b0;
    chk("b2b_count", firsts.size(), 3);
    for (int i = 0; i < firsts.size() && i < 3; i++) chk("b2b_first_at", firsts[i], 10 * i);
    repeat (4) @(negedge CP);
    chk("b2b_stopped", busy, 0);

    // Abort at bit 5.
    A = 8'hA5; B = 8'h3C; load = 1'b1;
    @(negedge CP); load = 1'b0;
    begin
      int k = 0;
      while (bit_idx != 5 && k < 20) begin @(negedge CP); k++; end
      chk("abort_reached_bit5", bit_idx, 5);
    end
    CI = 1'b1; #1;
    chk("abort_outputs", {x1, x2, valid, first, busy, done, bit_idx}, 0);
    dcnt = 0;
    @(negedge CP); CI = 1'b0;
    repeat (12) @(negedge CP);
    chk("abort_no_done", dcnt, 0);
    A = 8'h3C; B = 8'hA5; load = 1'b1;
    @(negedge CP); load = 1'b0;
    chk("restart_bit0", {valid, first, bit_idx, x1, x2}, {1'b1, 1'b1, 3'd0, 1'b0, 1'b1});
    wait_done("restart");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage for the two-input serial Mealy circuit. That circuit consumes x1/x2 one bit per CP and holds its state in a D flip-flop.
- Captures two N-bit operands from EGO1 switches on a load request. Shifts them out LSB-first on x1/x2, one bit per advance.
- Flags the first bit with `first`, so the consumer can clear its state flip-flop.
- Reports busy/done for LED display.

Parameters:
- N, 8, operand width in bits (N >= 2)
- IW, 3, width of bit_idx; must satisfy 2**IW >= N

Ports:
- CP  input  1  system clock, rising-edge active
- CI  input  1  asynchronous, active-high reset
- load  input  1  start request; sampled in IDLE only
- A  input  N  operand A (switch bank), feeds x1
- B  input  N  operand B (switch bank), feeds x2
- step  input  1  single-step button; used only when SINGLE_STEP_EN is defined, ignored otherwise
- x1  output  1  current bit of A
- x2  output  1  current bit of B
- valid  output  1  x1/x2 carry a live bit this cycle
- first  output  1  high while bit 0 is presented
- bit_idx  output  IW  index of the bit currently presented
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (CI=1, asynchronous, takes effect immediately):
  - state=IDLE; shift registers sa=0, sb=0; cnt=0.
  - All outputs 0: x1, x2, valid, first, bit_idx, busy, done.
- Output derivation:
  - x1=sa[0] and x2=sb[0], both gated with valid (0 outside SHIFT).
  - valid=busy=(state==SHIFT); bit_idx=cnt; first=valid&&(cnt==0).
  - All outputs are decoded from registers only; no combinational path from inputs.
- "advance": equals 1 every cycle in SHIFT (free-running mode).
- IDLE:
  - load=1 at edge k: sa<=A, sb<=B, cnt<=0, state<=SHIFT.
  - A[0]/B[0] appear on x1/x2 after edge k.
  - load=0: stay in IDLE; sa/sb keep their last values; outputs stay 0.
- SHIFT:
  - On advance with cnt<N-1: sa<=sa>>1, sb<=sb>>1 (zero-fill), cnt<=cnt+1.
  - On advance with cnt==N-1: state<=DONE, cnt<=0.
  - Bit i is presented during the cycle after edge k+i, i=0..N-1. Exactly N valid cycles in free-running mode.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- load handling outside IDLE:
  - load in SHIFT or DONE is ignored; no restart or re-capture.
  - load held high continuously: a new transfer starts on the first IDLE cycle. Sequence per transfer is N valid cycles, 1 done cycle, 1 idle cycle.
- A/B changes during SHIFT have no effect (operands are latched).
- CI asserted mid-transfer aborts immediately to IDLE with all outputs 0. No done pulse is produced.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - step passes through a 2-FF synchroniser and a rising-edge detector.
  - advance = the detected edge (one pulse per press); the transfer progresses one bit per press.
  - Entry from IDLE on load is unchanged, so bit 0 appears without a press.
  - valid/first stay high while waiting for a press.
  - Synchroniser flops reset to 0 by CI.
- Not defined:
  - advance is tied to 1; step is unused; no extra flops.

Test Plan:
- Reset: CI=1 mid-run then released -> all outputs 0; state IDLE; no done pulse.
- Basic transfer, N=8, A=8'hA5, B=8'h3C, load pulse at edge k:
  - Edges k+1..k+8 give x1=1,0,1,0,0,1,0,1 and x2=0,0,1,1,1,1,0,0.
  - first high only for bit 0; bit_idx counts 0..7.
  - done=1 for exactly the cycle after bit 7; busy low afterwards.
- Load ignored while busy: second load at bit 3 with A=8'hFF -> stream continues 8'hA5 bits unchanged; exactly 8 valid cycles.
- Back-to-back: load held high for 30 cycles -> transfers repeat with period N+2=10 cycles; first pulses every 10 cycles.
- Abort: CI pulse at bit 5 -> outputs 0 within the same cycle; next load restarts from bit 0 with first=1.
- SINGLE_STEP_EN defined, 3 presses each held 20 cycles -> bit_idx goes 0->1->2->3, one increment per press; valid stays 1; no advance without a press.
